serial_tx: RTL

//   Parallel-in, serial-out frame transmitter: the sending end of the lab's single-wire serial link.

---
 rtl/serial_tx_if.sv | 30 +++
 rtl/serial_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/serial_tx_if.sv
// Word handshake and serial line bundle between a lab word producer and serial_tx.
// The producer holds the master side; the transmitter holds the slave side.
interface serial_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              tx;
   logic              tx_busy;
   logic              tx_done;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  tx,
      input  tx_busy,
      input  tx_done
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output tx,
      output tx_busy,
      output tx_done
   );
endinterface

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start(0), data LSB first,
// optional even parity, stop(1). Each bit is held for CLKS_PER_BIT clocks.
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   serial_tx_if.slave bus
);
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [BIT_W-1:0] BIT_ZERO    = {BIT_W{1'b0}};
   localparam logic [BIT_W-1:0] BIT_ONE     = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_W - 1);
   localparam logic             STOP_ONLY   = (CLKS_PER_BIT == 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [BIT_W-1:0]  bit_q;
   logic              par_q;
   logic              tx_q;
   logic              ready_q;
   logic              done_q;
   logic              bit_end_s;
   logic              done_next_s;

   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   assign shift_d     = shift_q >> 1;
   assign bit_end_s   = (cnt_q == CNT_LAST);
   // tx_done is registered, so it is armed one cycle before the stop bit's last cycle.
   assign done_next_s = (CLKS_PER_BIT > 1) && (cnt_q == CNT_PRELAST);

   // Frame sequencer: state, bit timing, shift register and registered line outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= {DATA_W{1'b0}};
         cnt_q   <= CNT_ZERO;
         bit_q   <= BIT_ZERO;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q  <= CNT_ZERO;
               bit_q  <= BIT_ZERO;
               done_q <= 1'b0;
               if (bus.tx_valid) begin
                  shift_q <= bus.tx_data;
                  par_q   <= even_parity(bus.tx_data);
                  tx_q    <= 1'b0;
                  ready_q <= 1'b0;
                  state_q <= START;
               end else begin
                  tx_q    <= 1'b1;
                  ready_q <= 1'b1;
               end
            end
            START, DATA, PARITY, STOP: begin
               if (!bit_end_s) begin
                  cnt_q  <= cnt_q + CNT_ONE;
                  done_q <= (state_q == STOP) && done_next_s;
               end else begin
                  cnt_q  <= CNT_ZERO;
                  done_q <= 1'b0;
                  case (state_q)
                     START: begin
                        state_q <= DATA;
                        bit_q   <= BIT_ZERO;
                        tx_q    <= shift_q[0];
                     end
                     DATA: begin
                        if (bit_q != BIT_LAST) begin
                           bit_q   <= bit_q + BIT_ONE;
                           shift_q <= shift_d;
                           tx_q    <= shift_d[0];
                        end else if (PARITY_EN) begin
                           state_q <= PARITY;
                           tx_q    <= par_q;
                        end else begin
                           state_q <= STOP;
                           tx_q    <= 1'b1;
                           done_q  <= STOP_ONLY;
                        end
                     end
                     PARITY: begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                        done_q  <= STOP_ONLY;
                     end
                     STOP: begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        ready_q <= 1'b1;
                     end
                     default: begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        ready_q <= 1'b1;
                     end
                  endcase
               end
            end
            default: begin
               // Illegal encoding: drop the frame and park the line high.
               state_q <= IDLE;
               cnt_q   <= CNT_ZERO;
               bit_q   <= BIT_ZERO;
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx       = tx_q;
   assign bus.tx_ready = ready_q;
   assign bus.tx_busy  = ~ready_q;
   assign bus.tx_done  = done_q;
endmodule
